// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dcache_ctrl
// Description : Direct-mapped, write-back, write-allocate data-cache
//               controller for the MEM stage. A hit returns the load word in
//               the same cycle or updates the line on a store. A miss stalls
//               the pipeline while the controller writes back a dirty victim
//               and then refills the line from a multi-cycle 128-bit memory.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i        in   1    clock
//   start_i      in   1    synchronous active-low reset
//   cpu_req_i    in   1    MEM-stage access valid
//   cpu_we_i     in   1    1 = store, 0 = load
//   cpu_addr_i   in   32   word-aligned byte address
//   cpu_wdata_i  in   32   store data
//   cpu_rdata_o  out  32   load data (non-zero only on a load hit)
//   stall_o      out  1    pipeline stall request
//   mem_req_o    out  1    memory transaction request
//   mem_we_o     out  1    1 = block write, 0 = block read
//   mem_addr_o   out  32   block address (low 4 bits zero)
//   mem_wdata_o  out  128  victim block
//   mem_ack_i    in   1    transaction done (only honoured while mem_req_o)
//   mem_rdata_i  in   128  refill block, valid with mem_ack_i
// ============================================================================
module dcache_ctrl #(
  parameter int INDEX_W = 4
) (
  input  logic         clk_i,
  input  logic         start_i,
  input  logic         cpu_req_i,
  input  logic         cpu_we_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_wdata_i,
  output logic [31:0]  cpu_rdata_o,
  output logic         stall_o,
  output logic         mem_req_o,
  output logic         mem_we_o,
  output logic [31:0]  mem_addr_o,
  output logic [127:0] mem_wdata_o,
  input  logic         mem_ack_i,
  input  logic [127:0] mem_rdata_i
);

  localparam int c_sets = 1 << INDEX_W;
  localparam int c_tagW = 28 - INDEX_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WBACK   = 2'd1,
    REFILL  = 2'd2,
    RESOLVE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_nextState;

  // Line storage: valid/dirty are reset, tag/data arrays are not.
  logic [c_sets-1:0] r_valid;
  logic [c_sets-1:0] r_dirty;
  logic [c_tagW-1:0] r_tag  [c_sets];
  logic [127:0]      r_data [c_sets];

  // Miss context captured when leaving IDLE; the memory side is driven only
  // from these registers so it cannot glitch with the CPU address.
  logic [INDEX_W-1:0] r_missIdx;
  logic [c_tagW-1:0]  r_missTag;
  logic [c_tagW-1:0]  r_victimTag;

  // Address decode of the current CPU access.
  logic [1:0]         w_word;
  logic [INDEX_W-1:0] w_idx;
  logic [c_tagW-1:0]  w_tag;
  logic               w_hit;
  logic               w_victimDirty;
  logic               w_unusedAddrBits;

  assign w_word           = cpu_addr_i[3:2];
  assign w_idx            = cpu_addr_i[4+INDEX_W-1:4];
  assign w_tag            = cpu_addr_i[31:4+INDEX_W];
  assign w_unusedAddrBits = ^cpu_addr_i[1:0];

  assign w_hit         = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_victimDirty = r_valid[w_idx] && r_dirty[w_idx];

  // Events that modify the arrays, shared by both sequential processes.
  logic w_idleMiss;
  logic w_storeHit;
  logic w_wbackDone;
  logic w_refillDone;

  assign w_idleMiss   = (r_state == IDLE) && cpu_req_i && !w_hit;
  assign w_storeHit   = (r_state == IDLE) && cpu_req_i && w_hit && cpu_we_i;
  assign w_wbackDone  = (r_state == WBACK)  && mem_ack_i;
  assign w_refillDone = (r_state == REFILL) && mem_ack_i;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!start_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_nextState = r_state;
    stall_o     = 1'b0;
    cpu_rdata_o = 32'h0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 128'h0;

    case (r_state)
      IDLE: begin
        if (cpu_req_i) begin
          if (w_hit) begin
            if (!cpu_we_i) begin
              cpu_rdata_o = r_data[w_idx][{w_word, 5'b0} +: 32];
            end
          end else begin
            // Stall in the same cycle so the access is held until resolved.
            stall_o     = 1'b1;
            w_nextState = w_victimDirty ? WBACK : REFILL;
          end
        end
      end

      WBACK: begin
        stall_o     = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {r_victimTag, r_missIdx, 4'h0};
        mem_wdata_o = r_data[r_missIdx];
        if (mem_ack_i) begin
          w_nextState = REFILL;
        end
      end

      REFILL: begin
        stall_o    = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = {r_missTag, r_missIdx, 4'h0};
        if (mem_ack_i) begin
          w_nextState = RESOLVE;
        end
      end

      RESOLVE: begin
        // One bubble so the held access re-evaluates as a hit in IDLE.
        stall_o     = 1'b1;
        w_nextState = IDLE;
      end

      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Valid / dirty bits (reset)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!start_i) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      if (w_storeHit) begin
        r_dirty[w_idx] <= 1'b1;
      end
      if (w_wbackDone) begin
        r_dirty[r_missIdx] <= 1'b0;
      end
      if (w_refillDone) begin
        r_valid[r_missIdx] <= 1'b1;
        r_dirty[r_missIdx] <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Tag/data arrays and miss context (not reset; frozen on the reset edge so
  // an abandoned transaction leaves no trace)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (start_i) begin
      if (w_storeHit) begin
        r_data[w_idx][{w_word, 5'b0} +: 32] <= cpu_wdata_i;
      end
      if (w_idleMiss) begin
        r_missIdx   <= w_idx;
        r_missTag   <= w_tag;
        r_victimTag <= r_tag[w_idx];
      end
      if (w_refillDone) begin
        r_data[r_missIdx] <= mem_rdata_i;
        r_tag[r_missIdx]  <= r_missTag;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_ctrl
// Description : Self-checking bench for dcache_ctrl. Hit behaviour is driven
//               from a vector table; misses, evictions and reset/ack corner
//               cases use hand-written sequences with a small memory
//               responder that acks on a chosen cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_ctrl;

  logic         clk_i = 1'b0;
  logic         start_i;
  logic         cpu_req_i;
  logic         cpu_we_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_wdata_i;
  logic [31:0]  cpu_rdata_o;
  logic         stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_wdata_o;
  logic         mem_ack_i;
  logic [127:0] mem_rdata_i;

  always #5 clk_i = ~clk_i;

  dcache_ctrl #(.INDEX_W(4)) dut (
    .clk_i       (clk_i),
    .start_i     (start_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_wdata_i (cpu_wdata_i),
    .cpu_rdata_o (cpu_rdata_o),
    .stall_o     (stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i)
  );

  int nPass  = 0;
  int nTotal = 0;

  typedef struct {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        expStall;
    logic [31:0] expRdata;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nTotal++;
    if (act === exp) begin
      nPass++;
    end else begin
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Apply CPU inputs just after a rising edge, return at the falling edge.
  task automatic drive(input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata);
    @(posedge clk_i);
    #1;
    cpu_req_i   = req;
    cpu_we_i    = we;
    cpu_addr_i  = addr;
    cpu_wdata_i = wdata;
    @(negedge clk_i);
  endtask

  // Memory responder for one miss: acks the n-th cycle of each request phase
  // and records what the controller presented. Returns at the first falling
  // edge where stall_o is low.
  task automatic runMiss(input int ackWbAt, input int ackRfAt, input logic [127:0] blk,
                         output int stallCnt, output int reqCnt,
                         output logic wbSeen, output logic [31:0] wbAddr,
                         output logic [127:0] wbData,
                         output logic rfSeen, output logic [31:0] rfAddr);
    int wbCnt = 0;
    int rfCnt = 0;
    stallCnt = 0;
    reqCnt   = 0;
    wbSeen   = 1'b0;
    wbAddr   = 32'h0;
    wbData   = 128'h0;
    rfSeen   = 1'b0;
    rfAddr   = 32'h0;
    for (int i = 0; i < 40 && stall_o; i++) begin
      stallCnt++;
      if (mem_req_o) begin
        reqCnt++;
        if (mem_we_o) begin
          wbSeen    = 1'b1;
          wbAddr    = mem_addr_o;
          wbData    = mem_wdata_o;
          wbCnt++;
          mem_ack_i = (wbCnt == ackWbAt);
        end else begin
          rfSeen      = 1'b1;
          rfAddr      = mem_addr_o;
          rfCnt++;
          mem_ack_i   = (rfCnt == ackRfAt);
          mem_rdata_i = blk;
        end
      end
      @(posedge clk_i);
      #1;
      mem_ack_i = 1'b0;
      @(negedge clk_i);
    end
    chk("missBound", stall_o, 1'b0);
  endtask

  int          sc, rc;
  logic        wbS, rfS;
  logic [31:0] wbA, rfA;
  logic [127:0] wbD;

  initial begin
    vecs[0] = '{1'b1, 1'b1, 32'h48, 32'h1234_5678, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'h48, 32'h0,         1'b0, 32'h1234_5678};
    vecs[2] = '{1'b1, 1'b0, 32'h40, 32'h0,         1'b0, 32'hA};
    vecs[3] = '{1'b1, 1'b0, 32'h44, 32'h0,         1'b0, 32'hB};
    vecs[4] = '{1'b1, 1'b0, 32'h4C, 32'h0,         1'b0, 32'hD};
    vecs[5] = '{1'b0, 1'b0, 32'h40, 32'h0,         1'b0, 32'h0};
    vecs[6] = '{1'b1, 1'b1, 32'h44, 32'hCAFE_F00D, 1'b0, 32'h0};
    vecs[7] = '{1'b1, 1'b0, 32'h44, 32'h0,         1'b0, 32'hCAFE_F00D};

    start_i     = 1'b0;
    cpu_req_i   = 1'b0;
    cpu_we_i    = 1'b0;
    cpu_addr_i  = 32'h0;
    cpu_wdata_i = 32'h0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = 128'h0;

    // Reset
    repeat (2) @(posedge clk_i);
    #1;
    start_i = 1'b1;
    @(negedge clk_i);
    chk("rst_stall", stall_o, 1'b0);
    chk("rst_memReq", mem_req_o, 1'b0);
    chk("rst_memWe", mem_we_o, 1'b0);
    chk("rst_memAddr", mem_addr_o, 32'h0);
    chk("rst_memWdata", mem_wdata_o, 128'h0);
    chk("rst_rdata", cpu_rdata_o, 32'h0);

    // Cold load miss, ack on third refill cycle
    drive(1'b1, 1'b0, 32'h40, 32'h0);
    runMiss(1, 3, {32'hD, 32'hC, 32'hB, 32'hA}, sc, rc, wbS, wbA, wbD, rfS, rfA);
    chk("cold_stallCycles", sc, 5);
    chk("cold_reqCycles", rc, 3);
    chk("cold_noWback", wbS, 1'b0);
    chk("cold_refillSeen", rfS, 1'b1);
    chk("cold_refillAddr", rfA, 32'h40);
    chk("cold_hitRdata", cpu_rdata_o, 32'hA);

    // Hit vectors
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      chk($sformatf("vec%0d_stall", i), stall_o, vecs[i].expStall);
      chk($sformatf("vec%0d_rdata", i), cpu_rdata_o, vecs[i].expRdata);
      chk($sformatf("vec%0d_memReq", i), mem_req_o, 1'b0);
    end
    chk("dirty4_set", dut.r_dirty[4], 1'b1);

    // Dirty eviction: write-back acked on 2nd cycle, refill on 1st
    drive(1'b1, 1'b0, 32'h140, 32'h0);
    runMiss(2, 1, {32'h1403, 32'h1402, 32'h1401, 32'h1400}, sc, rc, wbS, wbA, wbD, rfS, rfA);
    chk("evict_stallCycles", sc, 5);
    chk("evict_reqCycles", rc, 3);
    chk("evict_wbackSeen", wbS, 1'b1);
    chk("evict_wbAddr", wbA, 32'h40);
    chk("evict_wbWord2", wbD[95:64], 32'h1234_5678);
    chk("evict_wbWord1", wbD[63:32], 32'hCAFE_F00D);
    chk("evict_wbWord0", wbD[31:0], 32'hA);
    chk("evict_refillAddr", rfA, 32'h140);
    chk("evict_rdata", cpu_rdata_o, 32'h1400);
    chk("dirty4_clear", dut.r_dirty[4], 1'b0);
    drive(1'b1, 1'b0, 32'h148, 32'h0);
    chk("evict_word2", cpu_rdata_o, 32'h1402);

    // Clean conflict miss back to 0x40
    drive(1'b1, 1'b0, 32'h40, 32'h0);
    runMiss(1, 2, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, sc, rc, wbS, wbA, wbD, rfS, rfA);
    chk("clean_noWback", wbS, 1'b0);
    chk("clean_refillAddr", rfA, 32'h40);
    chk("clean_stallCycles", sc, 4);
    chk("clean_reqCycles", rc, 2);
    chk("clean_rdata", cpu_rdata_o, 32'hC0);

    // Immediate ack
    drive(1'b1, 1'b0, 32'h240, 32'h0);
    runMiss(1, 1, {32'h2403, 32'h2402, 32'h2401, 32'h2400}, sc, rc, wbS, wbA, wbD, rfS, rfA);
    chk("imm_stallCycles", sc, 3);
    chk("imm_reqCycles", rc, 1);
    chk("imm_refillAddr", rfA, 32'h240);
    chk("imm_rdata", cpu_rdata_o, 32'h2400);

    // Reset in the middle of a refill with an ack on the reset edge
    drive(1'b1, 1'b0, 32'h80, 32'h0);
    chk("rstMid_idleStall", stall_o, 1'b1);
    chk("rstMid_idleNoReq", mem_req_o, 1'b0);
    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    chk("rstMid_refillReq", mem_req_o, 1'b1);
    chk("rstMid_refillAddr", mem_addr_o, 32'h80);
    start_i     = 1'b0;
    mem_ack_i   = 1'b1;
    mem_rdata_i = {4{32'hBAD0_BAD0}};
    @(posedge clk_i);
    #1;
    start_i   = 1'b1;
    mem_ack_i = 1'b0;
    @(negedge clk_i);
    chk("rstMid_state", dut.r_state, 2'd0);
    chk("rstMid_memReq", mem_req_o, 1'b0);
    chk("rstMid_valid8", dut.r_valid[8], 1'b0);
    chk("rstMid_missAgain", stall_o, 1'b1);
    runMiss(1, 1, {32'h803, 32'h802, 32'h801, 32'h800}, sc, rc, wbS, wbA, wbD, rfS, rfA);
    chk("rstMid_reStall", sc, 3);
    chk("rstMid_reAddr", rfA, 32'h80);
    chk("rstMid_rdata", cpu_rdata_o, 32'h800);

    // Stray ack while idle
    drive(1'b0, 1'b0, 32'h80, 32'h0);
    mem_ack_i   = 1'b1;
    mem_rdata_i = {4{32'hDEAD_BEEF}};
    @(posedge clk_i);
    #1;
    mem_ack_i = 1'b0;
    @(negedge clk_i);
    chk("stray_stall", stall_o, 1'b0);
    chk("stray_memReq", mem_req_o, 1'b0);
    chk("stray_state", dut.r_state, 2'd0);
    drive(1'b1, 1'b0, 32'h84, 32'h0);
    chk("stray_hitStall", stall_o, 1'b0);
    chk("stray_rdata", cpu_rdata_o, 32'h801);

    drive(1'b0, 1'b0, 32'h0, 32'h0);
    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data-cache controller in the MEM stage.
- Sits between the EX/MEM outputs (address, store data, mem read/write) and a multi-cycle 128-bit data memory.
- Raises stall_o to freeze PC/IFID/IDEX/EXMEM and hold MEMWB while it sequences write-back and refill transactions.
- On a hit it returns the load word in the same cycle, which feeds ReadData into MEMWB.

Parameters:
- INDEX_W, 4: set index width; number of sets = 2^INDEX_W; tag width = 28-INDEX_W.

Ports:
- clk_i  in  1  clock.
- start_i  in  1  synchronous active-low reset.
- cpu_req_i  in  1  MEM-stage access valid (MemRead | MemWrite).
- cpu_we_i  in  1  1 = store, 0 = load.
- cpu_addr_i  in  32  byte address; word-aligned.
- cpu_wdata_i  in  32  store data.
- cpu_rdata_o  out  32  load data; valid when cpu_req_i & ~cpu_we_i & ~stall_o.
- stall_o  out  1  pipeline stall request.
- mem_req_o  out  1  memory transaction request.
- mem_we_o  out  1  1 = block write, 0 = block read.
- mem_addr_o  out  32  block address, low 4 bits always 0.
- mem_wdata_o  out  128  victim block.
- mem_ack_i  in  1  transaction done; sampled at posedge only while mem_req_o=1.
- mem_rdata_i  in  128  refill block, valid with mem_ack_i.

Behaviour:
- Address split:
  - word select = addr[3:2]
  - index = addr[4+INDEX_W-1:4]
  - tag = addr[31:4+INDEX_W]
- Storage: per set, valid, dirty, tag and a 128-bit data block. Word n occupies bits [32n+31:32n].
- States: IDLE, WBACK, REFILL, RESOLVE.
- hit = valid[index] & (tag[index] == tag). Combinational, evaluated in IDLE only.
- IDLE, no request: stall_o=0; no state change.
- IDLE, request hit: stall_o=0.
  - Load: cpu_rdata_o = selected word, combinational, same cycle.
  - Store: at posedge, the selected word is written and dirty set.
- IDLE, request miss: stall_o=1 combinationally in the same cycle.
  - Next state is WBACK if the victim is valid & dirty, else REFILL.
- WBACK:
  - mem_req_o=1, mem_we_o=1.
  - mem_addr_o = {victim tag, index, 4'h0}; mem_wdata_o = victim block.
  - Held until mem_ack_i, then go to REFILL. Victim dirty is cleared on ack.
- REFILL:
  - mem_req_o=1, mem_we_o=0, mem_addr_o = {tag, index, 4'h0}.
  - On mem_ack_i: data = mem_rdata_i, tag written, valid=1, dirty=0; go to RESOLVE.
- RESOLVE: stall_o=1, no memory request; go to IDLE. The held access then hits in IDLE.
- stall_o = 1 in WBACK, REFILL and RESOLVE, and in IDLE on a miss.
- mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o are decoded from the registered state and registered victim/miss info. They are stable for the whole transaction and drop the cycle after ack.
- The CPU holds cpu_* stable while stall_o=1. The controller latches the miss address on leaving IDLE and uses the latched copy.
- Outputs when idle or not reading: cpu_rdata_o = 0 unless it is a load hit; mem_wdata_o = 0 outside WBACK; mem_addr_o = 0 in IDLE and RESOLVE.
- mem_ack_i while mem_req_o=0 is ignored. An ack in the first cycle of a request state is legal and completes that state.
- Reset (start_i=0 at posedge):
  - state=IDLE; all valid and dirty cleared.
  - All outputs 0 from the next cycle.
  - Data and tag arrays are not cleared.
- Reset mid-transaction abandons it: mem_req_o drops the cycle after the reset edge, and no array update occurs on that edge even if mem_ack_i=1.
- Miss penalty: 1 (IDLE) + refill wait + 1 (RESOLVE) cycles, plus the write-back wait if the victim is dirty.

Test Plan:
- Cold load miss: after reset, load 0x0000_0040 (set 4, tag 0); memory acks the 3rd REFILL cycle with block {32'hD,32'hC,32'hB,32'hA}.
  - Required: stall_o high for 5 cycles.
  - Required: mem_addr_o = 0x40, mem_we_o=0.
  - Required: the next cycle hits, stall_o=0, cpu_rdata_o = 0xA.
- Store hit then load: store 0x1234_5678 to 0x48 after the above; no stall.
  - Required: a load of 0x48 the next cycle returns 0x1234_5678.
  - Required: dirty[4]=1.
- Dirty eviction: load 0x0000_0140 (set 4, tag 1).
  - Required: WBACK first, with mem_we_o=1, mem_addr_o=0x40 and mem_wdata_o word2 = 0x1234_5678.
  - Required: then REFILL with mem_addr_o=0x140; final data comes from the refill.
- Clean conflict miss: load 0x140 then 0x40 with no stores in between.
  - Required: no WBACK; the only transaction is REFILL at 0x40.
- Immediate ack: mem_ack_i=1 in the first REFILL cycle.
  - Required: total stall = 3 cycles; mem_req_o high exactly 1 cycle.
- Reset mid-REFILL: start_i=0 for one posedge with mem_ack_i=1 on that edge.
  - Required: state IDLE, mem_req_o=0.
  - Required: a load of the same address misses again.
- Stray ack: mem_ack_i pulsed while mem_req_o=0 causes no state or array change.
